poly_host_port: RTL and testbench

//  Host-side BRAM port of the AMNS multiplier. Streams operands A, B, M and M_prime into the

---
 rtl/poly_host_pkg.sv | 45 ++++
 rtl/poly_host_skid_fifo.sv | 55 +++++
 rtl/poly_host_port.sv | 158 +++++++++++++++
 tb/tb_poly_host_port.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_host_pkg.sv
// Shared types and layout helpers for the AMNS multiplier host BRAM port.
// Latency: n/a (package).  Backpressure: n/a.
// Build option POLY_HOST_PORT_BRAM_OREG_EN selects a two-cycle BRAM read latency.
package poly_host_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        READ  = 3'd4
    } poly_host_state_t;

`ifdef POLY_HOST_PORT_BRAM_OREG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    // One extra slot covers the beat the consumer may be holding off.
    localparam int FIFO_DEPTH = RD_LAT + 1;

    // Region bases in word addresses; operands are packed A, B, M, M_prime, then RES.
    function automatic int base_b(input int n, input int s);
        return n * s;
    endfunction

    function automatic int base_m(input int n, input int s);
        return 2 * n * s;
    endfunction

    function automatic int base_mprime(input int n, input int s);
        return 3 * n * s;
    endfunction

    function automatic int base_res(input int n, input int s);
        return 3 * n * s + n;
    endfunction

    // Number of operand words streamed in before the core is started.
    function automatic int load_words(input int n, input int s);
        return 3 * n * s + n;
    endfunction

endpackage

// File: rtl/poly_host_skid_fifo.sv
// Small circular FIFO holding BRAM read data until the result stream takes it.
// Latency: one cycle from push to head visible.  Backpressure: caller must not push when full.
// Head data is presented combinationally; occupancy is exported for credit accounting.
module poly_host_skid_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage and pointers; reset also clears storage so the head reads zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign rdata = mem[rd_ptr];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/poly_host_port.sv
// Host BRAM port: streams A/B/M/M_prime into BRAM, starts the core, streams RES back out.
// Latency: start one cycle after last operand; first result RD_LAT+1 cycles after mm_done_i.
// Backpressure: reads issued only against FIFO credit, so m_ready_i low never drops a word.
// Option POLY_HOST_PORT_BRAM_OREG_EN: BRAM output register on, read latency 2 (default 1).
module poly_host_port
    import poly_host_pkg::*;
#(
    parameter int WORD_WIDTH = 17,
    parameter int N          = 5,
    parameter int S          = 4,
    parameter int ADDR_W     = $clog2(4 * N * S + N) + 1
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [WORD_WIDTH-1:0] s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [WORD_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_last_o,
    output logic                  mm_start_o,
    input  logic                  mm_done_i,
    output logic                  bram_en_o,
    output logic                  bram_we_o,
    output logic [ADDR_W-1:0]     bram_addr_o,
    output logic [WORD_WIDTH-1:0] bram_din_o,
    input  logic [WORD_WIDTH-1:0] bram_dout_i,
    output logic                  busy_o
);

    localparam int NS    = N * S;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OC_W  = (NS > 1) ? $clog2(NS) : 1;

    localparam logic [ADDR_W-1:0] LOAD_LAST = ADDR_W'(load_words(N, S) - 1);
    localparam logic [ADDR_W-1:0] RES_BASE  = ADDR_W'(base_res(N, S));
    localparam logic [ADDR_W-1:0] RES_END   = ADDR_W'(base_res(N, S) + NS);
    localparam logic [OC_W-1:0]   OUT_LAST  = OC_W'(NS - 1);

    poly_host_state_t state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [OC_W-1:0]   out_cnt_q, out_cnt_d;
    logic [RD_LAT-1:0] rd_pipe_q;
    logic              rd_issue;
    logic              beat_acc;

    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [WORD_WIDTH-1:0] fifo_head;

    int free_slots;
    int in_flight;

    // Ready is forced low while reset is held so every output reads zero during reset.
    assign s_ready_o = reset_i && ((state_q == IDLE) || (state_q == LOAD));
    assign beat_acc  = s_valid_i && s_ready_o;

    assign m_valid_o = !fifo_empty;
    assign m_data_o  = fifo_head;
    assign fifo_pop  = m_valid_o && m_ready_i;
    assign m_last_o  = m_valid_o && (state_q == READ) && (out_cnt_q == OUT_LAST);
    assign busy_o    = (state_q != IDLE);

    // A slot freed by this cycle's pop counts as credit; that is what keeps 1 word/cycle.
    assign free_slots = FIFO_DEPTH - int'(fifo_count) + int'(fifo_pop);
    assign in_flight  = $countones(rd_pipe_q);

    // State, address counter, output beat counter and read-return tracking.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            out_cnt_q <= '0;
            rd_pipe_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_cnt_q    <= out_cnt_d;
            rd_pipe_q[0] <= rd_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe_q[i] <= rd_pipe_q[i-1];
            end
        end
    end

    // Next-state and BRAM port drive; load writes are combinational from the handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_cnt_d   = out_cnt_q;
        bram_en_o   = 1'b0;
        bram_we_o   = 1'b0;
        bram_addr_o = '0;
        bram_din_o  = '0;
        mm_start_o  = 1'b0;
        rd_issue    = 1'b0;
        case (state_q)
            IDLE, LOAD: begin
                if (beat_acc) begin
                    bram_en_o   = 1'b1;
                    bram_we_o   = 1'b1;
                    bram_addr_o = cnt_q;
                    bram_din_o  = s_data_i;
                    cnt_d       = cnt_q + 1'b1;
                    state_d     = (cnt_q == LOAD_LAST) ? START : LOAD;
                end
            end
            START: begin
                mm_start_o = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                if (mm_done_i) begin
                    state_d   = READ;
                    cnt_d     = RES_BASE;
                    out_cnt_d = '0;
                end
            end
            READ: begin
                if ((cnt_q != RES_END) && (free_slots > in_flight)) begin
                    rd_issue    = 1'b1;
                    bram_en_o   = 1'b1;
                    bram_addr_o = cnt_q;
                    cnt_d       = cnt_q + 1'b1;
                end
                if (fifo_pop) begin
                    out_cnt_d = out_cnt_q + 1'b1;
                    if (out_cnt_q == OUT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    poly_host_skid_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clock_i),
        .rst_n (reset_i),
        .push  (rd_pipe_q[RD_LAT-1]),
        .wdata (bram_dout_i),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_poly_host_port.sv
// Bench for poly_host_port: operand load, core handshake and result readback against a BRAM model.
// Latency: n/a.  Backpressure: result stream ready is toggled randomly in some passes.
// Builds with or without POLY_HOST_PORT_BRAM_OREG_EN; the BRAM model follows RD_LAT.
module tb_poly_host_port;
    import poly_host_pkg::*;

    localparam int WW = 17;
    localparam int N  = 5;
    localparam int S  = 4;
    localparam int NS = N * S;
    localparam int AW = $clog2(4 * N * S + N) + 1;
    localparam int LOAD_WORDS = 3 * NS + N;
    localparam int RES_BASE   = 3 * NS + N;

    logic          clock_i = 1'b0;
    logic          reset_i;
    logic [WW-1:0] s_data_i;
    logic          s_valid_i;
    logic          s_ready_o;
    logic [WW-1:0] m_data_o;
    logic          m_valid_o;
    logic          m_ready_i;
    logic          m_last_o;
    logic          mm_start_o;
    logic          mm_done_i;
    logic          bram_en_o;
    logic          bram_we_o;
    logic [AW-1:0] bram_addr_o;
    logic [WW-1:0] bram_din_o;
    logic [WW-1:0] bram_dout_i;
    logic          busy_o;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt   = 0;
    int rx_cnt   = 0;

    logic [AW-1:0] exp_addr_q [$];
    logic [WW-1:0] exp_wdat_q [$];
    logic [WW-1:0] exp_res_q  [$];

    logic [WW-1:0] bram_mem [256];
    logic [WW-1:0] rd0, rd1;

    always #5 clock_i = ~clock_i;

    poly_host_port dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .s_data_i    (s_data_i),
        .s_valid_i   (s_valid_i),
        .s_ready_o   (s_ready_o),
        .m_data_o    (m_data_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_last_o    (m_last_o),
        .mm_start_o  (mm_start_o),
        .mm_done_i   (mm_done_i),
        .bram_en_o   (bram_en_o),
        .bram_we_o   (bram_we_o),
        .bram_addr_o (bram_addr_o),
        .bram_din_o  (bram_din_o),
        .bram_dout_i (bram_dout_i),
        .busy_o      (busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // BRAM model: synchronous write, read data RD_LAT cycles after the address.
    always @(posedge clock_i) begin
        if (bram_en_o && bram_we_o) bram_mem[bram_addr_o] <= bram_din_o;
        if (bram_en_o && !bram_we_o) rd0 <= bram_mem[bram_addr_o];
        rd1 <= rd0;
    end
    assign bram_dout_i = (RD_LAT == 2) ? rd1 : rd0;

    // Write monitor: every BRAM write must match the next expected operand beat.
    always @(negedge clock_i) begin
        if (bram_en_o && bram_we_o) begin
            wr_cnt++;
            if (exp_addr_q.size() == 0) begin
                chk("wr_extra", 32'(bram_addr_o), 32'hFFFF_FFFF);
            end else begin
                chk("wr_addr", 32'(bram_addr_o), 32'(exp_addr_q.pop_front()));
                chk("wr_data", 32'(bram_din_o), 32'(exp_wdat_q.pop_front()));
            end
        end
    end

    // Read monitor: each consumed result beat is popped from the scoreboard.
    always @(negedge clock_i) begin
        if (m_valid_o && m_ready_i) begin
            if (exp_res_q.size() == 0) begin
                chk("rd_extra", 32'(m_data_o), 32'hFFFF_FFFF);
            end else begin
                chk("rd_data", 32'(m_data_o), 32'(exp_res_q.pop_front()));
                chk("rd_last", 32'(m_last_o), 32'(rx_cnt == NS - 1));
            end
            rx_cnt++;
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {25'd0, s_ready_o, m_valid_o, m_last_o, mm_start_o,
                            bram_en_o, bram_we_o, busy_o}, 32'd0);
        chk({tag, "_addr"}, 32'(bram_addr_o), 32'd0);
        chk({tag, "_din"}, 32'(bram_din_o), 32'd0);
        chk({tag, "_mdat"}, 32'(m_data_o), 32'd0);
    endtask

    // Streams n beats (data = index); optional random gaps and an mm_done_i pulse at beat done_at.
    task automatic load_beats(input int n, input bit gaps, input int done_at);
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                int idle = $urandom_range(0, 2);
                for (int g = 0; g < idle; g++) begin
                    s_valid_i = 1'b0;
                    s_data_i  = WW'($urandom);
                    @(posedge clock_i); #1;
                end
            end
            chk("s_ready", 32'(s_ready_o), 32'd1);
            s_valid_i = 1'b1;
            s_data_i  = WW'(k);
            mm_done_i = (k == done_at);
            exp_addr_q.push_back(AW'(k));
            exp_wdat_q.push_back(WW'(k));
            @(posedge clock_i); #1;
            s_valid_i = 1'b0;
            mm_done_i = 1'b0;
        end
    endtask

    // Full load followed by start-pulse checks.
    task automatic full_load(input bit gaps, input int done_at);
        int w0 = wr_cnt;
        load_beats(LOAD_WORDS, gaps, done_at);
        chk("start_pulse", 32'(mm_start_o), 32'd1);
        chk("ready_drop", 32'(s_ready_o), 32'd0);
        chk("wr_total", 32'(wr_cnt - w0), 32'(LOAD_WORDS));
        @(posedge clock_i); #1;
        chk("start_once", 32'(mm_start_o), 32'd0);
        chk("busy_wait", 32'(busy_o), 32'd1);
    endtask

    // Pulses mm_done_i and drains RES; abort_at >= 0 asserts reset after that many beats.
    task automatic read_back(input bit rnd, input int abort_at);
        int cyc;
        for (int i = 0; i < NS; i++) exp_res_q.push_back(WW'(17'h100 + i));
        rx_cnt    = 0;
        m_ready_i = 1'b1;
        mm_done_i = 1'b1;
        @(posedge clock_i); #1;
        mm_done_i = 1'b0;
        if (!rnd) begin
            for (int c = 0; c < RD_LAT; c++) begin
                @(posedge clock_i); #1;
                chk("lat_early", 32'(m_valid_o), 32'd0);
            end
            @(posedge clock_i); #1;
            chk("lat_first", 32'(m_valid_o), 32'd1);
        end
        cyc = 0;
        while (busy_o && cyc < 400) begin
            if (rnd) m_ready_i = $urandom_range(0, 1) == 1;
            if (abort_at >= 0 && rx_cnt == abort_at) begin
                reset_i = 1'b0;
                #1;
                chk_all_zero("rst_read");
                exp_res_q.delete();
                m_ready_i = 1'b0;
                @(posedge clock_i); #1;
                reset_i = 1'b1;
                @(posedge clock_i); #1;
                return;
            end
            @(posedge clock_i); #1;
            cyc++;
        end
        chk("rd_timeout", 32'(busy_o), 32'd0);
        chk("rd_count", 32'(rx_cnt), 32'(NS));
        chk("res_left", 32'(exp_res_q.size()), 32'd0);
        m_ready_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) bram_mem[i] = '0;
        for (int i = 0; i < NS; i++) bram_mem[RES_BASE + i] = WW'(17'h100 + i);
        reset_i   = 1'b0;
        s_valid_i = 1'b0;
        s_data_i  = '0;
        m_ready_i = 1'b0;
        mm_done_i = 1'b0;
        #3;
        chk_all_zero("rst");
        repeat (2) @(posedge clock_i);
        #1;
        reset_i = 1'b1;
        #1;
        chk("idle_ready", 32'(s_ready_o), 32'd1);
        chk("idle_busy", 32'(busy_o), 32'd0);
        @(posedge clock_i); #1;

        // Back-to-back load, then plain readback with latency check.
        full_load(1'b0, -1);
        repeat (3) @(posedge clock_i);
        #1;
        chk("wait_hold", 32'(busy_o), 32'd1);
        read_back(1'b0, -1);
        chk("idle_after", 32'(busy_o), 32'd0);

        // mm_done_i ignored in IDLE and during a gapped load; readback under random backpressure.
        mm_done_i = 1'b1;
        @(posedge clock_i); #1;
        mm_done_i = 1'b0;
        @(posedge clock_i); #1;
        chk("done_idle", 32'(busy_o), 32'd0);
        full_load(1'b1, 10);
        read_back(1'b1, -1);

        // Reset mid-load, fresh load from address 0, reset mid-read, then a clean pass.
        load_beats(30, 1'b0, -1);
        reset_i = 1'b0;
        #1;
        chk_all_zero("rst_load");
        @(posedge clock_i); #1;
        reset_i = 1'b1;
        @(posedge clock_i); #1;
        full_load(1'b0, -1);
        read_back(1'b0, 7);
        chk("rst_read_idle", 32'(busy_o), 32'd0);
        full_load(1'b1, -1);
        read_back(1'b1, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
